// File: rtl/avalon_conv_read_master.sv
// avalon_conv_read_master
//   Avalon-MM read master feeding the convolution engine. On a START pulse it
//   fetches WORD_COUNT 32-bit words from BASE_ADDR with up to MAX_OUTSTANDING
//   pipelined reads. It buffers the returned words in a FIFO and streams them
//   out one byte per beat, byte 0 first, over a valid/ready pixel handshake.
//
//   Optional feature macro: CONV_RD_PERF_EN adds stall_cycles_o, a count of
//   BUSY cycles spent with a read stalled by waitrequest.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   start_i                    one-cycle pulse, latches base_addr_i / word_count_i
//   base_addr_i, word_count_i  transfer byte address (bits[1:0] ignored), word count
//   busy_o, done_o             transfer in progress / one-cycle completion pulse
//   avm_*                      Avalon-MM read master interface
//   pix_data_o/valid_o/last_o  pixel stream out
//   pix_ready_i                downstream accepts the current pixel
//   stall_cycles_o             (CONV_RD_PERF_EN only) waitrequest stall counter
module avalon_conv_read_master #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int ADDR_W          = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [15:0]       word_count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic              avm_read_o,
  output logic [3:0]        avm_byte_en_o,
  input  logic              avm_waitrequest_i,
  input  logic [31:0]       avm_readdata_i,
  input  logic              avm_readdatavalid_i,
  output logic [7:0]        pix_data_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              pix_last_o
`ifdef CONV_RD_PERF_EN
  ,
  output logic [31:0]       stall_cycles_o
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wc_q, wc_d;
  logic [15:0]       req_left_q, req_left_d;  // words still to request
  logic [15:0]       wpop_q, wpop_d;          // words fully emitted
  logic [CW-1:0]     out_q, out_d;            // reads in flight
  logic [CW-1:0]     cnt_q, cnt_d;            // words held in the FIFO
  logic [PW-1:0]     wr_q, rd_q;
  logic [1:0]        byte_q, byte_d;
  logic              done_q, done_d;
  logic [31:0]       mem_q [FIFO_DEPTH];

  logic [CW:0]       credit;
  logic              can_issue, accept, push, pop, hs, start_ok;
  logic [31:0]       head;

  // The request depends only on registered state, so once raised it cannot
  // drop under waitrequest: returns and pops can only add credit.
  assign credit    = {1'b0, out_q} + {1'b0, cnt_q};
  assign can_issue = (state_q == ISSUE) &&
                     (out_q < CW'(MAX_OUTSTANDING)) &&
                     (credit < (CW+1)'(FIFO_DEPTH)) &&
                     (req_left_q != 16'd0);
  assign accept    = can_issue && !avm_waitrequest_i;
  // A return with nothing in flight is a leftover from before a reset.
  assign push      = avm_readdatavalid_i && (out_q != '0);
  assign start_ok  = (state_q == IDLE) && start_i;

  // The word being unpacked stays at the FIFO head until its byte 3 is taken.
  assign head        = mem_q[rd_q];
  assign pix_valid_o = (cnt_q != '0);
  assign pix_data_o  = pix_valid_o ? head[{byte_q, 3'b000} +: 8] : 8'h00;
  assign pix_last_o  = pix_valid_o && (byte_q == 2'd3) && (wpop_q == wc_q - 16'd1);
  assign hs          = pix_valid_o && pix_ready_i;
  assign pop         = hs && (byte_q == 2'd3);

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign avm_read_o    = can_issue;
  assign avm_address_o = addr_q;
  assign avm_byte_en_o = 4'hF;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wc_d       = wc_q;
    req_left_d = req_left_q;
    wpop_d     = wpop_q;
    byte_d     = byte_q;
    done_d     = 1'b0;
    out_d      = out_q + CW'(accept) - CW'(push);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    if (hs)  byte_d = byte_q + 2'd1;
    if (pop) wpop_d = wpop_q + 16'd1;
    if (accept) begin
      addr_d     = addr_q + ADDR_W'(4);
      req_left_d = req_left_q - 16'd1;
    end
    case (state_q)
      IDLE: if (start_ok) begin
        addr_d     = base_addr_i & ~ADDR_W'(3);
        wc_d       = word_count_i;
        req_left_d = word_count_i;
        wpop_d     = '0;
        byte_d     = '0;
        if (word_count_i == 16'd0) done_d  = 1'b1;
        else                       state_d = ISSUE;
      end
      ISSUE: if (accept && req_left_q == 16'd1) state_d = DRAIN;
      // The last pixel can only leave after every word has returned.
      DRAIN: if (hs && pix_last_o) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wc_q       <= '0;
      req_left_q <= '0;
      wpop_q     <= '0;
      out_q      <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      byte_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wc_q       <= wc_d;
      req_left_q <= req_left_d;
      wpop_q     <= wpop_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      done_q     <= done_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= avm_readdata_i;
  end

`ifdef CONV_RD_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                           stall_q <= '0;
    else if (start_ok)                                   stall_q <= '0;
    else if (busy_o && avm_read_o && avm_waitrequest_i) stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_avalon_conv_read_master.sv
module tb_avalon_conv_read_master;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [31:0] base = '0;
  logic [15:0] wc = '0;
  logic        busy, done, avm_read, pix_valid, pix_last;
  logic        waitreq = 1'b0, rdv = 1'b0, pix_ready = 1'b0;
  logic [31:0] addr, rdata = '0;
  logic [3:0]  be;
  logic [7:0]  pdata;
`ifdef CONV_RD_PERF_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  avalon_conv_read_master dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .word_count_i(wc),
    .busy_o(busy), .done_o(done), .avm_address_o(addr), .avm_read_o(avm_read),
    .avm_byte_en_o(be), .avm_waitrequest_i(waitreq), .avm_readdata_i(rdata),
    .avm_readdatavalid_i(rdv), .pix_data_o(pdata), .pix_valid_o(pix_valid),
    .pix_ready_i(pix_ready), .pix_last_o(pix_last)
`ifdef CONV_RD_PERF_EN
    , .stall_cycles_o(stall_cycles)
`endif
  );

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory image: mode 0 is the ramp image relative to mem_base, mode 1 a hash.
  int          mem_mode = 0;
  logic [31:0] mem_base = '0;
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (mem_mode == 0) return ((a - mem_base) >> 2) * 32'h04030201;
    return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
  endfunction

  typedef struct {logic [7:0] d; bit l; bit e;} pix_t;
  typedef struct {logic [31:0] d; int due; int ep;} ret_t;
  pix_t exp_pix[$];
  ret_t ret_q[$];

  // Slave / sink knobs
  int wait_pct = 0, lat = 1, rdy_mode = 0;
  bit stall2 = 1'b0;
  int stall_ct = 0, epoch = 0;

  // Model state
  int          cyc = 0, bout = 0, bbuf = 0, req_cnt = 0, exp_words = 0, reads_seen = 0;
  logic [31:0] exp_base = '0, prev_addr = '0;
  bit          busy_exp = 1'b0, done_exp = 1'b0, prev_rw = 1'b0, busy_now;
  int          done_cnt = 0, pix_cnt = 0;
  logic [31:0] first_addr = '0, last_addr = '0;
  logic [7:0]  last_pd = '0, pd5 = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("busy", busy, busy_exp);
      check("done", done, done_exp);
      if (done) done_cnt++;
      if (prev_rw) begin
        check("read_hold", avm_read, 1'b1);
        check("addr_hold", addr, prev_addr);
      end
      if (!busy_exp || req_cnt >= exp_words) check("extra_read", avm_read, 1'b0);
      if (exp_pix.size() == 0) check("pix_valid_idle", pix_valid, 1'b0);
      if (pix_valid && exp_pix.size() > 0) begin
        check("pix_data", pdata, exp_pix[0].d);
        check("pix_last", pix_last, exp_pix[0].l);
      end
      if (!pix_valid) check("pix_last_idle", pix_last, 1'b0);
      if (bbuf > 0) check("pix_valid_late", pix_valid, 1'b1);
    end
    // read returns, in request order
    rdv = 1'b0;
    rdata = $urandom;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      rdv = 1'b1;
      rdata = ret_q[0].d;
      if (!rst && ret_q[0].ep == epoch) begin bout--; bbuf++; end
      void'(ret_q.pop_front());
    end
    if (rst) begin
      busy_exp = 0; done_exp = 0; exp_pix.delete();
      bout = 0; bbuf = 0; req_cnt = 0; prev_rw = 0; stall_ct = 0; waitreq = 0;
    end else begin
      busy_now = busy_exp;
      done_exp = 1'b0;
      if (stall2) begin
        if (avm_read && stall_ct < 2) begin waitreq = 1'b1; stall_ct++; end
        else begin waitreq = 1'b0; stall_ct = 0; end
      end else waitreq = ($urandom_range(99) < wait_pct);
      if (avm_read && !waitreq) begin
        check("addr", addr, exp_base + 32'(4 * req_cnt));
        check("byte_en", be, 4'hF);
        if (req_cnt == 0) first_addr = addr;
        last_addr = addr;
        ret_q.push_back('{word_at(addr), cyc + lat, epoch});
        req_cnt++; bout++; reads_seen++;
        check("outstanding_max", bout <= 4, 1'b1);
      end
      check("credit", bout + bbuf <= 8, 1'b1);
      prev_rw = avm_read && waitreq;
      prev_addr = addr;
      case (rdy_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ($urandom_range(99) < 70);
        default: pix_ready = 1'b0;
      endcase
      if (pix_valid && pix_ready && exp_pix.size() > 0) begin
        pix_cnt++;
        last_pd = pdata;
        if (pix_cnt == 6) pd5 = pdata;
        if (exp_pix[0].e) bbuf--;
        void'(exp_pix.pop_front());
        if (exp_pix.size() == 0) begin done_exp = 1'b1; busy_exp = 1'b0; end
      end
      if (start && !busy_now) begin
        if (wc == 16'd0) done_exp = 1'b1;
        else begin
          busy_exp = 1'b1;
          exp_base = {base[31:2], 2'b00};
          exp_words = int'(wc);
          req_cnt = 0; pix_cnt = 0;
          for (int w = 0; w < int'(wc); w++) begin
            logic [31:0] v;
            v = word_at(exp_base + 32'(4 * w));
            for (int k = 0; k < 4; k++)
              exp_pix.push_back('{v[8*k +: 8], (w == int'(wc) - 1) && (k == 3), k == 3});
          end
        end
      end
    end
  end

  task automatic kick(input logic [31:0] b, input logic [15:0] n);
    @(posedge clk); #1;
    base = b; wc = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input bit inject, output int t);
    t = 0;
    while (done_cnt == d0 && t < budget) begin
      if (inject && t == 20) begin base = base ^ 32'h40; wc = wc + 16'd3; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    if (done_cnt == d0) begin
      vectors++; miscompares++;
      $display("FAIL timeout: no DONE within %0d cycles", budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_read"}, avm_read, 1'b0);
    check({tag, "_addr"}, addr, 32'h0);
    check({tag, "_pvalid"}, pix_valid, 1'b0);
    check({tag, "_plast"}, pix_last, 1'b0);
    check({tag, "_pdata"}, pdata, 8'h00);
  endtask

  initial begin
    int d0, t, r0;
    // reset state
    #1 rst = 1'b1;
    #2 check_reset_outputs("reset");
`ifdef CONV_RD_PERF_EN
    check("reset_stall", stall_cycles, 32'h0);
`endif
    repeat (3) @(posedge clk); #1 rst = 1'b0;

    // 1: ramp image, zero-wait slave, sink always ready
    mem_mode = 0; mem_base = 32'h100; wait_pct = 0; lat = 1; rdy_mode = 0;
    d0 = done_cnt;
    kick(32'h100, 16'd196);
    wait_done(d0, 3000, 1'b0, t);
    repeat (3) @(posedge clk); #1;
    check("t1_pixels", pix_cnt, 784);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_first_addr", first_addr, 32'h100);
    check("t1_last_addr", last_addr, 32'h40C);
    check("t1_last_pixel", last_pd, 8'h0E);
    check("t1_pixel5", pd5, 8'h02);
    check("t1_throughput", t <= 800, 1'b1);

    // 2: empty transfer
    d0 = done_cnt; r0 = reads_seen;
    kick(32'h200, 16'd0);
    repeat (4) @(posedge clk); #1;
    check("t2_done_once", done_cnt - d0, 1);
    check("t2_no_reads", reads_seen - r0, 0);

    // 3: random waitrequest, 3-cycle latency, random sink, ignored START mid-run
    mem_mode = 1; wait_pct = 50; lat = 3; rdy_mode = 1;
    d0 = done_cnt;
    kick(32'h1000 + ($urandom & 32'hFF3), 16'd60);
    wait_done(d0, 4000, 1'b1, t);
    repeat (3) @(posedge clk); #1;
    check("t3_pixels", pix_cnt, 240);
    check("t3_done_once", done_cnt - d0, 1);

    // 4: sink stalled for 100 cycles mid-transfer
    wait_pct = 0; lat = 2; rdy_mode = 0;
    d0 = done_cnt;
    kick(32'h8000, 16'd40);
    repeat (30) @(posedge clk); #1 rdy_mode = 2;
    repeat (100) @(posedge clk); #1;
    check("t4_buffered", bbuf, 8);
    check("t4_inflight", bout, 0);
    check("t4_read_stopped", avm_read, 1'b0);
    rdy_mode = 0;
    wait_done(d0, 2000, 1'b0, t);
    repeat (3) @(posedge clk); #1;
    check("t4_pixels", pix_cnt, 160);

    // 5: reset during DRAIN with two reads in flight
    lat = 6;
    kick(32'h4000, 16'd4);
    t = 0;
    while (!(req_cnt == 4 && bout == 2) && t < 300) begin @(posedge clk); #1; t++; end
    if (t >= 300) begin vectors++; miscompares++; $display("FAIL t5_setup: never reached 2 in flight"); end
    epoch++;
    rst = 1'b1;
    #1 check_reset_outputs("t5_reset");
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    t = 0;
    while (ret_q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    repeat (5) @(posedge clk); #1;
    check("t5_no_stray_pixel", pix_valid, 1'b0);
    lat = 1;
    d0 = done_cnt;
    kick(32'h3000, 16'd8);
    wait_done(d0, 500, 1'b0, t);
    repeat (3) @(posedge clk); #1;
    check("t5_pixels", pix_cnt, 32);

`ifdef CONV_RD_PERF_EN
    // 6: exactly two waitrequest cycles per read
    stall2 = 1'b1; lat = 1;
    d0 = done_cnt;
    kick(32'h2000, 16'd8);
    wait_done(d0, 500, 1'b0, t);
    repeat (5) @(posedge clk); #1;
    check("t6_stall_cycles", stall_cycles, 32'd16);
    stall2 = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
